// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage with req/gnt/rvalid bus handshake and load extension
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_valid,
    input  logic        lsu_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        lsu_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [2:0]    op_f3;
    logic [1:0]    op_off;

    logic          illegal_f3;
    logic          misalign;
    logic          req_bad;
    logic          start;
    logic          timeout_hit;
    logic          err_now;
    logic          load_capture;
    logic [3:0]    be_c;
    logic [31:0]   wd_c;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   ext_data;

    // Request legality: reserved funct3 codes, unsigned stores and misaligned halves/words
    always_comb begin
        illegal_f3 = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (lsu_we && funct3[2]);
        misalign   = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        req_bad    = illegal_f3 || misalign;
        start      = (state == IDLE) && lsu_valid && !req_bad;
    end

    // Byte enables and lane-replicated store data for the access size
    always_comb begin
        be_c = 4'b1111;
        wd_c = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_c = 4'b0001 << addr[1:0];
                wd_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_c = 4'b0011 << addr[1:0];
                wd_c = {2{wdata[15:0]}};
            end
            default: begin
                be_c = 4'b1111;
                wd_c = wdata;
            end
        endcase
    end

    // Timeout fires on the last allowed cycle only when the awaited handshake is absent
    always_comb begin
        timeout_hit = (count == CW'(TIMEOUT - 1)) &&
                      (((state == REQ) && !mem_gnt) || ((state == WAIT) && !mem_rvalid));
        err_now     = ((state == IDLE) && lsu_valid && req_bad) || timeout_hit;
        lsu_err     = err_now;
        stall       = lsu_valid && (state != DONE) && !err_now;
    end

    // Read data is captured either with gnt in REQ or later in WAIT
    always_comb begin
        load_capture = !mem_we && mem_rvalid &&
                       (((state == REQ) && mem_gnt) || (state == WAIT));
    end

    // Lane selection and sign/zero extension of the returned word
    always_comb begin
        byte_sel = mem_rdata[8*op_off +: 8];
        half_sel = op_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_f3)
            3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ext_data = {24'd0, byte_sel};
            3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  ext_data = {16'd0, half_sel};
            default: ext_data = mem_rdata;
        endcase
    end

    // Next-state logic; DONE always returns to IDLE so a request is never reissued
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = REQ;
            end
            REQ: begin
                if (mem_gnt) begin
                    if (mem_we || mem_rvalid) state_next = DONE;
                    else                      state_next = WAIT;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (mem_rvalid)       state_next = DONE;
                else if (timeout_hit) state_next = IDLE;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Bus outputs, cycle counter, saved access shape, load result and done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            count     <= '0;
            op_f3     <= 3'd0;
            op_off    <= 2'd0;
            rdata     <= 32'd0;
            done      <= 1'b0;
        end else begin
            done <= (state_next == DONE);
            if (start) begin
                mem_req   <= 1'b1;
                mem_we    <= lsu_we;
                mem_be    <= be_c;
                mem_addr  <= {addr[31:2], 2'b00};
                mem_wdata <= wd_c;
                op_f3     <= funct3;
                op_off    <= addr[1:0];
                count     <= '0;
            end else if ((state == REQ) || (state == WAIT)) begin
                count <= count + 1'b1;
            end
            if ((state == REQ) && (mem_gnt || timeout_hit)) begin
                mem_req <= 1'b0;
            end
            if (load_capture) begin
                rdata <= ext_data;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_valid;
    logic        lsu_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        done;
    logic        lsu_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .lsu_valid  (lsu_valid),
        .lsu_we     (lsu_we),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .rdata      (rdata),
        .done       (done),
        .lsu_err    (lsu_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus;
        lsu_valid  = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        lsu_valid = 1'b0; lsu_we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_done", done, 0);
        chk("rst_lsu_err", lsu_err, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_stall", stall, 0);
        reset = 1'b1;
        step;

        // SW 0x100, gnt in first REQ cycle
        lsu_valid = 1'b1; lsu_we = 1'b1; funct3 = 3'b010; addr = 32'h100; wdata = 32'hDEADBEEF;
        mem_gnt = 1'b1;
        #1;
        chk("sw_idle_stall", stall, 1);
        chk("sw_idle_req", mem_req, 0);
        step;
        chk("sw_req", mem_req, 1);
        chk("sw_we", mem_we, 1);
        chk("sw_be", mem_be, 4'b1111);
        chk("sw_addr", mem_addr, 32'h100);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_req_done", done, 0);
        step;
        chk("sw_done", done, 1);
        chk("sw_done_stall", stall, 0);
        chk("sw_done_req", mem_req, 0);
        idle_bus;
        step;
        chk("sw_after_done", done, 0);

        // SB 0x103
        lsu_valid = 1'b1; lsu_we = 1'b1; funct3 = 3'b000; addr = 32'h103; wdata = 32'h000000A5;
        step;
        chk("sb_be", mem_be, 4'b1000);
        chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("sb_addr", mem_addr, 32'h100);
        mem_gnt = 1'b1;
        step;
        chk("sb_done", done, 1);
        idle_bus;
        step;

        // LBU 0x103, rvalid together with gnt
        lsu_valid = 1'b1; lsu_we = 1'b0; funct3 = 3'b100; addr = 32'h103;
        step;
        chk("lbu_be", mem_be, 4'b1000);
        chk("lbu_we", mem_we, 0);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hA5000000;
        step;
        chk("lbu_done", done, 1);
        chk("lbu_rdata", rdata, 32'h000000A5);
        idle_bus;
        step;

        // LB 0x103 through WAIT
        lsu_valid = 1'b1; lsu_we = 1'b0; funct3 = 3'b000; addr = 32'h103;
        step;
        mem_gnt = 1'b1;
        step;
        mem_gnt = 1'b0;
        #1;
        chk("lb_wait_stall", stall, 1);
        chk("lb_wait_req", mem_req, 0);
        chk("lb_wait_done", done, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'hA5000000;
        step;
        chk("lb_done", done, 1);
        chk("lb_rdata", rdata, 32'hFFFFFFA5);
        idle_bus;
        step;

        // LH 0x102, gnt after 3 cycles, rvalid 2 cycles later
        lsu_valid = 1'b1; lsu_we = 1'b0; funct3 = 3'b001; addr = 32'h102;
        step;
        for (int i = 0; i < 3; i++) begin
            chk("lh_req_stall", stall, 1);
            chk("lh_req_hold", mem_req, 1);
            step;
        end
        chk("lh_be", mem_be, 4'b1100);
        chk("lh_addr", mem_addr, 32'h100);
        mem_gnt = 1'b1;
        step;
        mem_gnt = 1'b0;
        #1;
        chk("lh_wait1_stall", stall, 1);
        step;
        mem_rvalid = 1'b1; mem_rdata = 32'h80010000;
        #1;
        chk("lh_wait2_stall", stall, 1);
        step;
        chk("lh_done", done, 1);
        chk("lh_rdata", rdata, 32'hFFFF8001);
        chk("lh_done_stall", stall, 0);
        idle_bus;
        step;

        // LW misaligned
        lsu_valid = 1'b1; lsu_we = 1'b0; funct3 = 3'b010; addr = 32'h101;
        #1;
        chk("lw_mis_err", lsu_err, 1);
        chk("lw_mis_stall", stall, 0);
        chk("lw_mis_req", mem_req, 0);
        step;
        lsu_valid = 1'b0;
        #1;
        chk("lw_mis_err_low", lsu_err, 0);
        chk("lw_mis_req_low", mem_req, 0);

        // SB with unsigned funct3 is illegal
        lsu_valid = 1'b1; lsu_we = 1'b1; funct3 = 3'b100; addr = 32'h100;
        #1;
        chk("sbu_err", lsu_err, 1);
        step;
        lsu_valid = 1'b0;
        #1;
        chk("sbu_req", mem_req, 0);
        chk("sbu_rdata_kept", rdata, 32'hFFFF8001);

        // Timeout: gnt never comes
        lsu_valid = 1'b1; lsu_we = 1'b0; funct3 = 3'b010; addr = 32'h200;
        step;
        for (int i = 0; i < 15; i++) begin
            chk("to_no_err", lsu_err, 0);
            chk("to_req_hold", mem_req, 1);
            step;
        end
        chk("to_err", lsu_err, 1);
        chk("to_err_stall", stall, 0);
        lsu_valid = 1'b0;
        step;
        chk("to_req_low", mem_req, 0);
        chk("to_err_low", lsu_err, 0);
        chk("to_done", done, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        step;
        mem_rvalid = 1'b0;
        chk("late_rvalid_rdata", rdata, 32'hFFFF8001);
        chk("late_rvalid_done", done, 0);

        // Reset asserted in WAIT
        lsu_valid = 1'b1; lsu_we = 1'b0; funct3 = 3'b010; addr = 32'h300;
        step;
        mem_gnt = 1'b1;
        step;
        mem_gnt = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_req", mem_req, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", lsu_err, 0);
        chk("midrst_be", mem_be, 0);
        chk("midrst_rdata", rdata, 0);
        step;
        reset = 1'b1;
        #1;
        chk("postrst_stall", stall, 1);
        step;
        chk("postrst_req", mem_req, 1);
        chk("postrst_addr", mem_addr, 32'h300);
        chk("postrst_be", mem_be, 4'b1111);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        step;
        chk("postrst_done", done, 1);
        chk("postrst_rdata", rdata, 32'hCAFEF00D);
        idle_bus;
        step;
        chk("postrst_idle", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
